sram_rdata_ctrl: RTL and testbench

- Read-return path of the AHB SRAM subsystem; the counterpart of the byte-lane write splitter in the SRAM core.
- Takes a read command (bank select plus active-low byte-chip-selects) and waits the SRAM read latency.
- Merges the eight 8-bit SRAM outputs (bank0 = q0..q3, bank1 = q4..q7) into one 32-bit read word, registered for the AHB slave.
- Signals busy and valid, and flags illegal chip-select patterns.

---
 rtl/sram_rdata_ctrl.sv | 128 ++++++++++++
 tb/tb_sram_rdata_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rdata_ctrl.sv
// Read-return path of the SRAM subsystem: captures a read command, waits the SRAM read
// latency, then merges the selected bank's byte outputs into one registered 32-bit word.
//
// state | meaning
// IDLE  | no read outstanding, accepting requests
// WAIT  | read latency counting down, rd_busy high
// DONE  | response cycle (rd_valid), back-to-back request accepted
module sram_rdata_ctrl #(
  parameter int unsigned RD_LAT     = 1,
  parameter bit          LANE_ALIGN = 1'b0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        rd_req,
  input  logic        bank_sel,
  input  logic [3:0]  bank0_csn,
  input  logic [3:0]  bank1_csn,
  input  logic [7:0]  sram_q0,
  input  logic [7:0]  sram_q1,
  input  logic [7:0]  sram_q2,
  input  logic [7:0]  sram_q3,
  input  logic [7:0]  sram_q4,
  input  logic [7:0]  sram_q5,
  input  logic [7:0]  sram_q6,
  input  logic [7:0]  sram_q7,
  output logic [31:0] hrdata,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        rd_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  csn_q, csn_d;
  logic        bank_q, bank_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        rd_err_q, rd_err_d;

  logic [3:0]  csn_act;
  logic        req_ok;
  logic [31:0] bytes_sel;
  logic [31:0] merged;
  logic        legal;

  assign csn_act   = bank_sel ? bank0_csn : bank1_csn;
  assign req_ok    = rd_req && (csn_act != 4'b1111);
  // Only the captured bank steers the merge; live bank_sel is ignored during WAIT.
  assign bytes_sel = bank_q ? {sram_q3, sram_q2, sram_q1, sram_q0}
                            : {sram_q7, sram_q6, sram_q5, sram_q4};

  always_comb begin
    merged = '0;
    legal  = 1'b1;
    case (csn_q)
      4'b1110: merged = {24'h0, bytes_sel[7:0]};
      4'b1101: merged = LANE_ALIGN ? {16'h0, bytes_sel[15:8], 8'h0}  : {24'h0, bytes_sel[15:8]};
      4'b1011: merged = LANE_ALIGN ? {8'h0, bytes_sel[23:16], 16'h0} : {24'h0, bytes_sel[23:16]};
      4'b0111: merged = LANE_ALIGN ? {bytes_sel[31:24], 24'h0}       : {24'h0, bytes_sel[31:24]};
      4'b1100: merged = {16'h0, bytes_sel[15:0]};
      4'b0011: merged = LANE_ALIGN ? {bytes_sel[31:16], 16'h0}       : {16'h0, bytes_sel[31:16]};
      4'b0000: merged = bytes_sel;
      default: legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    csn_d    = csn_q;
    bank_d   = bank_q;
    hrdata_d = hrdata_q;
    rd_err_d = rd_err_q;
    case (state_q)
      IDLE, DONE: begin
        if (req_ok) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          csn_d   = csn_act;
          bank_d  = bank_sel;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          hrdata_d = merged;
          rd_err_d = ~legal;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      csn_q    <= 4'd0;
      bank_q   <= 1'b0;
      hrdata_q <= 32'd0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csn_q    <= csn_d;
      bank_q   <= bank_d;
      hrdata_q <= hrdata_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign hrdata   = hrdata_q;
  assign rd_err   = rd_err_q;
  assign rd_valid = (state_q == DONE);
  assign rd_busy  = (state_q == WAIT);

endmodule

// File: tb/tb_sram_rdata_ctrl.sv
// Bench for sram_rdata_ctrl: three instances (RD_LAT=1/align 0, RD_LAT=2/align 0,
// RD_LAT=2/align 1) share stimulus; a vector table plus directed multi-cycle sequences.
module tb_sram_rdata_ctrl;

  logic        hclk;
  logic        hreset;
  logic        rd_req;
  logic        bank_sel;
  logic [3:0]  bank0_csn;
  logic [3:0]  bank1_csn;
  logic [63:0] qv;

  logic [31:0] hrdata_1, hrdata_2, hrdata_3;
  logic        valid_1, valid_2, valid_3;
  logic        err_1, err_2, err_3;
  logic        busy_1, busy_2, busy_3;

  int n_chk  = 0;
  int n_fail = 0;

  sram_rdata_ctrl #(.RD_LAT(1), .LANE_ALIGN(1'b0)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .rd_req(rd_req), .bank_sel(bank_sel),
    .bank0_csn(bank0_csn), .bank1_csn(bank1_csn),
    .sram_q0(qv[7:0]),   .sram_q1(qv[15:8]),  .sram_q2(qv[23:16]), .sram_q3(qv[31:24]),
    .sram_q4(qv[39:32]), .sram_q5(qv[47:40]), .sram_q6(qv[55:48]), .sram_q7(qv[63:56]),
    .hrdata(hrdata_1), .rd_valid(valid_1), .rd_err(err_1), .rd_busy(busy_1)
  );

  sram_rdata_ctrl #(.RD_LAT(2), .LANE_ALIGN(1'b0)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .rd_req(rd_req), .bank_sel(bank_sel),
    .bank0_csn(bank0_csn), .bank1_csn(bank1_csn),
    .sram_q0(qv[7:0]),   .sram_q1(qv[15:8]),  .sram_q2(qv[23:16]), .sram_q3(qv[31:24]),
    .sram_q4(qv[39:32]), .sram_q5(qv[47:40]), .sram_q6(qv[55:48]), .sram_q7(qv[63:56]),
    .hrdata(hrdata_2), .rd_valid(valid_2), .rd_err(err_2), .rd_busy(busy_2)
  );

  sram_rdata_ctrl #(.RD_LAT(2), .LANE_ALIGN(1'b1)) u_dut3 (
    .hclk(hclk), .hreset(hreset), .rd_req(rd_req), .bank_sel(bank_sel),
    .bank0_csn(bank0_csn), .bank1_csn(bank1_csn),
    .sram_q0(qv[7:0]),   .sram_q1(qv[15:8]),  .sram_q2(qv[23:16]), .sram_q3(qv[31:24]),
    .sram_q4(qv[39:32]), .sram_q5(qv[47:40]), .sram_q6(qv[55:48]), .sram_q7(qv[63:56]),
    .hrdata(hrdata_3), .rd_valid(valid_3), .rd_err(err_3), .rd_busy(busy_3)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        bsel;
    logic [3:0]  csn0;
    logic [3:0]  csn1;
    logic [63:0] q;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        err;
  } vec_t;

  localparam int NV = 10;
  localparam logic [63:0] QA = 64'h88A5_6655_4433_2211;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Request in cycle T; RD_LAT=1 answers at T+2, RD_LAT=2 at T+3.
  task automatic run_vec(input int i);
    bank_sel  = vecs[i].bsel;
    bank0_csn = vecs[i].csn0;
    bank1_csn = vecs[i].csn1;
    qv        = vecs[i].q;
    rd_req    = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("busy_l1_t1", i, 32'(busy_1), 32'd1);
    chk("busy_l2_t1", i, 32'(busy_2), 32'd1);
    chk("valid_l1_t1", i, 32'(valid_1), 32'd0);
    tick();
    chk("valid_l1", i, 32'(valid_1), 32'd1);
    chk("hrdata_l1", i, hrdata_1, vecs[i].exp0);
    chk("err_l1", i, 32'(err_1), 32'(vecs[i].err));
    chk("valid_l2_t2", i, 32'(valid_2), 32'd0);
    chk("busy_l2_t2", i, 32'(busy_2), 32'd1);
    tick();
    chk("valid_l2", i, 32'(valid_2), 32'd1);
    chk("hrdata_l2a0", i, hrdata_2, vecs[i].exp0);
    chk("err_l2a0", i, 32'(err_2), 32'(vecs[i].err));
    chk("valid_l2a1", i, 32'(valid_3), 32'd1);
    chk("hrdata_l2a1", i, hrdata_3, vecs[i].exp1);
    chk("err_l2a1", i, 32'(err_3), 32'(vecs[i].err));
    chk("valid_l1_t3", i, 32'(valid_1), 32'd0);
    tick();
    chk("valid_l2_t4", i, 32'(valid_2), 32'd0);
    chk("busy_l2_t4", i, 32'(busy_2), 32'd0);
    chk("hold_hrdata_l2", i, hrdata_2, vecs[i].exp0);
    chk("hold_err_l2", i, 32'(err_2), 32'(vecs[i].err));
  endtask

  logic [31:0] words[4];
  logic        seen;

  initial begin
    vecs[0] = '{1'b1, 4'b0000, 4'b1111, QA, 32'h44332211, 32'h44332211, 1'b0};
    vecs[1] = '{1'b0, 4'b0000, 4'b1011, QA, 32'h000000A5, 32'h00A50000, 1'b0};
    vecs[2] = '{1'b1, 4'b1010, 4'b0000, QA, 32'h00000000, 32'h00000000, 1'b1};
    vecs[3] = '{1'b1, 4'b1110, 4'b0000, QA, 32'h00000011, 32'h00000011, 1'b0};
    vecs[4] = '{1'b1, 4'b0111, 4'b1100, QA, 32'h00000044, 32'h44000000, 1'b0};
    vecs[5] = '{1'b0, 4'b0011, 4'b1101, QA, 32'h00000066, 32'h00006600, 1'b0};
    vecs[6] = '{1'b0, 4'b0000, 4'b0001, QA, 32'h00000000, 32'h00000000, 1'b1};
    vecs[7] = '{1'b0, 4'b1110, 4'b1100, QA, 32'h00006655, 32'h00006655, 1'b0};
    vecs[8] = '{1'b0, 4'b0000, 4'b0011, QA, 32'h000088A5, 32'h88A50000, 1'b0};
    vecs[9] = '{1'b0, 4'b1110, 4'b0000, QA, 32'h88A56655, 32'h88A56655, 1'b0};
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h12345678;
    words[2] = 32'hA5A55A5A;
    words[3] = 32'h0F1E2D3C;

    hreset = 1'b1; rd_req = 1'b0; bank_sel = 1'b0;
    bank0_csn = 4'hF; bank1_csn = 4'hF; qv = '0;
    tick();
    tick();
    chk("rst_hrdata", 0, hrdata_2, 32'd0);
    chk("rst_valid", 0, 32'(valid_2), 32'd0);
    chk("rst_err", 0, 32'(err_2), 32'd0);
    chk("rst_busy", 0, 32'(busy_2), 32'd0);
    hreset = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset two cycles mid-WAIT aborts the read.
    bank_sel = 1'b1; bank0_csn = 4'b0000; qv = QA; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("pre_rst_busy", 0, 32'(busy_2), 32'd1);
    hreset = 1'b1;
    tick();
    tick();
    chk("midrst_hrdata_l2", 0, hrdata_2, 32'd0);
    chk("midrst_hrdata_l1", 0, hrdata_1, 32'd0);
    chk("midrst_hrdata_l2a1", 0, hrdata_3, 32'd0);
    chk("midrst_busy", 0, 32'(busy_2), 32'd0);
    chk("midrst_valid", 0, 32'(valid_2), 32'd0);
    hreset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (valid_1 || valid_2 || valid_3) seen = 1'b1;
    end
    chk("no_valid_after_rst", 0, 32'(seen), 32'd0);
    run_vec(0);

    // Halfword with csn/bank toggled while waiting.
    bank_sel = 1'b1; bank0_csn = 4'b0011; bank1_csn = 4'b1100;
    qv = 64'h5566_7788_ABCD_7788; rd_req = 1'b1;
    tick();
    rd_req = 1'b0; bank_sel = 1'b0; bank0_csn = 4'b1111; bank1_csn = 4'b0000;
    tick();
    chk("half_valid_l1", 0, 32'(valid_1), 32'd1);
    chk("half_hrdata_l1", 0, hrdata_1, 32'h0000ABCD);
    bank_sel = 1'b1; bank0_csn = 4'b1110;
    tick();
    chk("half_valid_l2", 0, 32'(valid_2), 32'd1);
    chk("half_hrdata_l2a0", 0, hrdata_2, 32'h0000ABCD);
    chk("half_hrdata_l2a1", 0, hrdata_3, 32'hABCD0000);
    chk("half_err_l2", 0, 32'(err_2), 32'd0);
    tick();

    // Nothing selected: request ignored.
    bank_sel = 1'b0; bank1_csn = 4'b1111; bank0_csn = 4'b0000; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("idle_busy", 0, 32'(busy_1 | busy_2 | busy_3), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (valid_1 || valid_2 || valid_3) seen = 1'b1;
    end
    chk("idle_no_valid", 0, 32'(seen), 32'd0);
    chk("idle_hrdata_kept", 0, hrdata_2, 32'h0000ABCD);

    // Back-to-back words on RD_LAT=1, one request every second cycle.
    bank_sel = 1'b1; bank0_csn = 4'b0000; bank1_csn = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      qv = {~words[i], words[i]};
      rd_req = 1'b1;
      if (i > 0) begin
        chk("b2b_valid", i, 32'(valid_1), 32'd1);
        chk("b2b_hrdata", i, hrdata_1, words[i-1]);
      end
      tick();
      rd_req = 1'b0;
      chk("b2b_busy", i, 32'(busy_1), 32'd1);
      chk("b2b_gap_valid", i, 32'(valid_1), 32'd0);
      tick();
    end
    chk("b2b_valid", 4, 32'(valid_1), 32'd1);
    chk("b2b_hrdata", 4, hrdata_1, words[3]);
    repeat (4) tick();

    // Request while busy is dropped.
    bank_sel = 1'b1; bank0_csn = 4'b0000; qv = {~words[0], words[0]}; rd_req = 1'b1;
    tick();
    bank0_csn = 4'b1100;
    chk("drop_busy", 0, 32'(busy_1), 32'd1);
    tick();
    rd_req = 1'b0;
    chk("drop_valid", 0, 32'(valid_1), 32'd1);
    chk("drop_hrdata", 0, hrdata_1, words[0]);
    tick();
    chk("drop_no_extra_valid", 0, 32'(valid_1), 32'd0);
    chk("drop_no_busy", 0, 32'(busy_1), 32'd0);
    tick();
    chk("drop_no_extra_valid", 1, 32'(valid_1), 32'd0);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
